// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the pattern-to-BCD decoder used by the
// display driver and the bus read-back path.
package seg7_pkg;

    // Active-low segment patterns, bit6 = g .. bit0 = a.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    localparam logic [1:0] SEL_D0 = 2'b01;
    localparam logic [1:0] SEL_D1 = 2'b10;

    function automatic logic [3:0] seg_to_bcd(input logic [6:0] pattern);
        case (pattern)
            SEG_0:   return 4'd0;
            SEG_1:   return 4'd1;
            SEG_2:   return 4'd2;
            SEG_3:   return 4'd3;
            SEG_4:   return 4'd4;
            SEG_5:   return 4'd5;
            SEG_6:   return 4'd6;
            SEG_7:   return 4'd7;
            SEG_8:   return 4'd8;
            SEG_9:   return 4'd9;
            default: return BCD_INVALID;
        endcase
    endfunction

endpackage

// File: rtl/seg7_digit_filter.sv
// One glitch-filter channel: accepts a segment pattern once it has been seen
// STABLE_CYCLES times in a row while this digit is selected.
module seg7_digit_filter
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sel,
    input  logic [6:0] seg,
    output logic       accept,
    output logic [6:0] code
);

    localparam int             CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [6:0]    cand;
    logic [CW-1:0] cnt;

    // Fires only on the transition into CNT_MAX, so a held pattern accepts once.
    assign accept = sel && (seg == cand) && (cnt == CNT_LAST);

    // NOTE: non-blocking assignments so every register here reads pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand <= SEG_BLANK;
            cnt  <= '0;
            code <= SEG_BLANK;
        end else if (!sel) begin
            cnt <= '0;
        end else if (seg != cand) begin
            cand <= seg;
            cnt  <= CW'(1);
        end else begin
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            if (accept)         code <= cand;
        end
    end

endmodule

// File: rtl/seg7_pair_reader.sv
// Reads a multiplexed active-low two-digit 7-segment bus back into BCD,
// a binary value 0..99 and per-digit zero/error flags.
module seg7_pair_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic [1:0] dig_sel,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic [6:0] value,
    output logic       zero1,
    output logic       zero0,
    output logic       err1,
    output logic       err0,
    output logic       valid,
    output logic       sel_err
);

    logic [6:0] s_seg;
    logic [1:0] s_sel;
    logic       accept0, accept1;
    logic [6:0] code0, code1;
    logic       fresh0, fresh1;
    logic       commit;
    logic [3:0] dec0, dec1;
    logic       bad0, bad1;
    logic [6:0] tens, sum;

    assign commit = fresh0 && fresh1;

    // dig_sel == 2'b11 matches neither channel, so both counters drop to zero.
    seg7_digit_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filt0 (
        .clk    (CLOCK_50),
        .rst_n  (rst_n),
        .sel    (s_sel == SEL_D0),
        .seg    (s_seg),
        .accept (accept0),
        .code   (code0)
    );

    seg7_digit_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filt1 (
        .clk    (CLOCK_50),
        .rst_n  (rst_n),
        .sel    (s_sel == SEL_D1),
        .seg    (s_seg),
        .accept (accept1),
        .code   (code1)
    );

    // NOTE: every signal written here is assigned on all paths, so no latch is inferred.
    always_comb begin
        dec1 = seg_to_bcd(code1);
        dec0 = seg_to_bcd(code0);
        bad1 = (dec1 == BCD_INVALID);
        bad0 = (dec0 == BCD_INVALID);
        tens = {3'b000, dec1};
        sum  = (bad1 || bad0) ? 7'd127 : (tens << 3) + (tens << 1) + {3'b000, dec0};
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            s_seg   <= SEG_BLANK;
            s_sel   <= '0;
            fresh0  <= 1'b0;
            fresh1  <= 1'b0;
            bcd1    <= '0;
            bcd0    <= '0;
            value   <= '0;
            zero1   <= 1'b0;
            zero0   <= 1'b0;
            err1    <= 1'b0;
            err0    <= 1'b0;
            valid   <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            s_seg   <= seg;
            s_sel   <= dig_sel;
            sel_err <= (s_sel == 2'b11);
            valid   <= commit;
            // A same-cycle accept re-arms its flag even while the commit clears it.
            fresh0  <= (fresh0 && !commit) || accept0;
            fresh1  <= (fresh1 && !commit) || accept1;
            if (commit) begin
                bcd1  <= dec1;
                bcd0  <= dec0;
                value <= sum;
                zero1 <= (code1 == SEG_0);
                zero0 <= (code0 == SEG_0);
                err1  <= bad1;
                err0  <= bad0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_pair_reader.sv
// Randomized scoreboard bench for seg7_pair_reader with a run-length reference model.
module tb_seg7_pair_reader;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg = 7'h7F;
    logic [1:0] dig_sel = 2'b00;
    logic [3:0] bcd1, bcd0;
    logic [6:0] value;
    logic       zero1, zero0, err1, err0, valid, sel_err;

    seg7_pair_reader #(.STABLE_CYCLES(STABLE)) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .seg      (seg),
        .dig_sel  (dig_sel),
        .bcd1     (bcd1),
        .bcd0     (bcd0),
        .value    (value),
        .zero1    (zero1),
        .zero0    (zero0),
        .err1     (err1),
        .err0     (err0),
        .valid    (valid),
        .sel_err  (sel_err)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [3:0] bcd1;
        logic [3:0] bcd0;
        logic [6:0] value;
        logic       zero1, zero0, err1, err0;
    } exp_t;

    // Independent digit table, index = digit value.
    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    exp_t       exp_q[$];
    logic [6:0] m_cand [2];
    int         m_run  [2];
    bit         m_fresh[2];
    logic [6:0] m_code [2];
    logic [1:0] p_sel;
    logic [6:0] p_seg;
    int         sel_err_exp = 0;

    function automatic int digit_of(input logic [6:0] c);
        int d = -1;
        for (int i = 0; i < 10; i++) if (c == pat[i]) d = i;
        return d;
    endfunction

    function automatic exp_t expect_pair(input logic [6:0] c1, input logic [6:0] c0);
        exp_t e;
        int b1 = digit_of(c1);
        int b0 = digit_of(c0);
        e.err1  = (b1 < 0);
        e.err0  = (b0 < 0);
        e.bcd1  = e.err1 ? 4'hF : 4'(b1);
        e.bcd0  = e.err0 ? 4'hF : 4'(b0);
        e.zero1 = (b1 == 0);
        e.zero0 = (b0 == 0);
        e.value = (e.err1 || e.err0) ? 7'd127 : 7'(b1 * 10 + b0);
        return e;
    endfunction

    // One call per clock edge; p_sel/p_seg is the sample taken at the previous edge.
    task automatic model_edge(input logic r, input logic [1:0] s, input logic [6:0] g);
        if (!r) begin
            for (int i = 0; i < 2; i++) begin
                m_cand[i] = 7'h7F; m_run[i] = 0; m_fresh[i] = 0; m_code[i] = 7'h7F;
            end
            p_sel = 2'b00;
            p_seg = 7'h7F;
            return;
        end
        if (m_fresh[0] && m_fresh[1]) begin
            exp_q.push_back(expect_pair(m_code[1], m_code[0]));
            m_fresh[0] = 0;
            m_fresh[1] = 0;
        end
        if (p_sel == 2'b11) sel_err_exp++;
        for (int i = 0; i < 2; i++) begin
            if (p_sel == 2'(1 << i)) begin
                if (p_seg == m_cand[i]) m_run[i]++;
                else begin
                    m_cand[i] = p_seg;
                    m_run[i]  = 1;
                end
                if (m_run[i] == STABLE) begin
                    m_code[i]  = m_cand[i];
                    m_fresh[i] = 1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        p_sel = s;
        p_seg = g;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic [1:0] s, input logic [6:0] g);
        @(negedge clk);
        dig_sel = s; seg = g; rst_n = 1'b1;
        @(posedge clk);
        model_edge(1'b1, s, g);
    endtask

    task automatic rst_cyc();
        @(negedge clk);
        dig_sel = 2'b00; seg = 7'h7F; rst_n = 1'b0;
        @(posedge clk);
        model_edge(1'b0, 2'b00, 7'h7F);
    endtask

    task automatic win(input logic [1:0] s, input logic [6:0] g, input int n);
        for (int k = 0; k < n; k++) cyc(s, g);
    endtask

    task automatic idle(input int n);
        win(2'b00, 7'h7F, n);
    endtask

    // ---------------- monitor ----------------
    int   n_valid = 0;
    int   n_selerr = 0;
    exp_t mon_e;
    exp_t last;

    always @(negedge clk) begin
        if (valid) begin
            n_valid++;
            last = '{bcd1, bcd0, value, zero1, zero0, err1, err0};
            check("valid_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("bcd1",  bcd1,  mon_e.bcd1);
                check("bcd0",  bcd0,  mon_e.bcd0);
                check("value", value, mon_e.value);
                check("zero1", zero1, mon_e.zero1);
                check("zero0", zero0, mon_e.zero0);
                check("err1",  err1,  mon_e.err1);
                check("err0",  err0,  mon_e.err0);
            end
        end
        if (sel_err) n_selerr++;
    end

    // ---------------- test sequence ----------------
    int v0, s0;

    initial begin
        rst_cyc();
        rst_cyc();
        #1;
        check("reset_outputs", int'({bcd1, bcd0, value, zero1, zero0, err1, err0, valid, sel_err}), 0);

        // 1: units "0", tens "2" -> 20
        v0 = n_valid;
        win(2'b01, pat[0], 6);
        win(2'b10, pat[2], 6);
        idle(3);
        check("t1_valid_count", n_valid - v0, 1);
        check("t1_value", last.value, 20);
        check("t1_bcd1",  last.bcd1, 2);
        check("t1_bcd0",  last.bcd0, 0);
        check("t1_zero0", last.zero0, 1);
        check("t1_err",   int'({last.err1, last.err0}), 0);

        // 2: units toggling 5/9 every 2 cycles never stabilises
        v0 = n_valid;
        for (int k = 0; k < 5; k++) begin
            win(2'b01, pat[5], 2);
            win(2'b01, pat[9], 2);
        end
        idle(3);
        check("t2_no_valid", n_valid - v0, 0);

        // 3: blank tens, units "7" -> error pair
        v0 = n_valid;
        win(2'b10, 7'h7F, 6);
        win(2'b01, pat[7], 6);
        idle(3);
        check("t3_valid_count", n_valid - v0, 1);
        check("t3_err1",  last.err1, 1);
        check("t3_bcd1",  last.bcd1, 15);
        check("t3_bcd0",  last.bcd0, 7);
        check("t3_value", last.value, 127);

        // 4: illegal select breaks the run
        v0 = n_valid; s0 = n_selerr;
        win(2'b01, pat[9], 3);
        cyc(2'b11, pat[9]);
        win(2'b01, pat[9], 3);
        idle(3);
        check("t4_sel_err", n_selerr - s0, 1);
        check("t4_no_valid", n_valid - v0, 0);

        // 5: reset mid-filter discards progress
        v0 = n_valid;
        win(2'b01, pat[0], 3);
        rst_cyc();
        #1;
        check("t5_reset_outputs", int'({bcd1, bcd0, value, zero1, zero0, err1, err0, valid, sel_err}), 0);
        win(2'b01, pat[0], 3);
        win(2'b10, pat[8], 6);
        idle(3);
        check("t5_no_accept_3", n_valid - v0, 0);
        win(2'b01, pat[0], 4);
        idle(3);
        check("t5_accept_4", n_valid - v0, 1);
        check("t5_value", last.value, 80);

        // 6: repeated 9,5 windows with blank gaps
        v0 = n_valid; s0 = n_selerr;
        for (int k = 0; k < 4; k++) begin
            win(2'b10, pat[9], 6);
            idle(1);
            win(2'b01, pat[5], 6);
            idle(1);
        end
        idle(3);
        check("t6_valid_count", n_valid - v0, 4);
        check("t6_value", last.value, 95);
        check("t6_no_sel_err", n_selerr - s0, 0);

        // Randomized windows, glitches, gaps, illegal selects and resets
        for (int w = 0; w < 200; w++) begin
            int r = $urandom_range(0, 39);
            int len = $urandom_range(1, 8);
            logic [1:0] s;
            logic [6:0] p;
            if (r == 39) begin
                rst_cyc();
                continue;
            end
            s = (r < 17) ? 2'b01 : (r < 34) ? 2'b10 : (r < 37) ? 2'b00 : 2'b11;
            p = ($urandom_range(0, 9) < 8) ? pat[$urandom_range(0, 9)] : 7'($urandom);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) cyc(s, 7'($urandom));
                else cyc(s, p);
            end
        end
        idle(10);
        check("scoreboard_drained", exp_q.size(), 0);
        check("sel_err_total", n_selerr, sel_err_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
